// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: K-code values, scrambler seed and ordered-set length.
// Used by the transmit scrambler and its per-symbol datapath.
package pcie_phy_pkg;

    localparam logic [7:0] COM = 8'hBC;  // K28.5
    localparam logic [7:0] SKP = 8'h1C;  // K28.0
    localparam logic [7:0] STP = 8'hFB;  // K27.7
    localparam logic [7:0] SDP = 8'h5C;  // K28.2
    localparam logic [7:0] END = 8'hFD;  // K29.7
    localparam logic [7:0] EDB = 8'hFE;  // K30.7
    localparam logic [7:0] IDL = 8'h7C;  // K28.3
    localparam logic [7:0] FTS = 8'h3C;  // K28.1
    localparam logic [7:0] EIE = 8'hFC;  // K28.7

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam int          OS_LEN    = 16;

    function automatic logic is_legal_k(input logic [7:0] sym);
        case (sym)
            8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scramble_byte.sv
// Combinational scrambler for one symbol: XORs D symbols with the LFSR stream
// and returns the LFSR state the next symbol in time should see.
module scramble_byte
    import pcie_phy_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic [7:0]  sym,
    input  logic        k,
    input  logic        bypass,
    input  logic [15:0] lfsr_in,
    output logic [7:0]  sym_scr,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr;
    logic [7:0]  mask;

    always_comb begin
        lfsr = lfsr_in;
        mask = '0;
        // LSB first: use bit 15, then Galois shift with taps 3/4/5 fed from bit 15
        for (int i = 0; i < 8; i++) begin
            mask[i] = lfsr[15];
            lfsr    = {lfsr[14:0], lfsr[15]} ^ {10'd0, {3{lfsr[15]}}, 3'd0};
        end

        sym_scr = (k || bypass) ? sym : (sym ^ mask);

        if (k && sym == COM)
            lfsr_out = SEED;
        else if (k && sym == SKP)
            lfsr_out = lfsr_in;
        else
            lfsr_out = lfsr;
    end

endmodule

// File: rtl/tx_scrambler.sv
// PCIe Gen1/Gen2 transmit scrambler, four symbols per clock, one cycle latency.
// Tracks COM reseed, SKP hold and the TS1/TS2 bypass window across the symbol chain.
module tx_scrambler #(
    parameter logic [15:0] LFSR_SEED = pcie_phy_pkg::LFSR_SEED,
    parameter int          OS_LEN    = pcie_phy_pkg::OS_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sym_in_1,
    input  logic [7:0] sym_in_2,
    input  logic [7:0] sym_in_3,
    input  logic [7:0] sym_in_4,
    input  logic [3:0] k_in,
    input  logic       scramble_disable,
    output logic [7:0] sym_out_1,
    output logic [7:0] sym_out_2,
    output logic [7:0] sym_out_3,
    output logic [7:0] sym_out_4,
    output logic [3:0] k_out,
    output logic       invalid_k
);

    localparam int         NSYM    = 4;
    localparam logic [3:0] OS_LAST = 4'(OS_LEN - 1);

    logic [NSYM-1:0][7:0] sym_in;
    logic [NSYM-1:0][7:0] sym_scr;

    assign sym_in = {sym_in_4, sym_in_3, sym_in_2, sym_in_1};

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_1, lfsr_2, lfsr_3, lfsr_4;
    logic        os_active_q, com_seen_q, dis_q;
    logic [3:0]  os_cnt_q;

    logic            os_act, os_com, is_com, is_pkt;
    logic [3:0]      os_cnt;
    logic [NSYM-1:0] bypass, k_bad;

    // Window state walks the symbols in time order; each slot sees the state
    // left by the slot before it. os_cnt holds the OS index of the next symbol.
    always_comb begin
        os_act = os_active_q;
        os_com = com_seen_q;
        os_cnt = os_cnt_q;
        bypass = '0;
        k_bad  = '0;
        is_com = 1'b0;
        is_pkt = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            is_com    = k_in[i] && (sym_in[i] == pcie_phy_pkg::COM);
            is_pkt    = k_in[i] && (sym_in[i] == pcie_phy_pkg::STP ||
                                    sym_in[i] == pcie_phy_pkg::SDP);
            // a D symbol right after COM is the first body symbol of a TS
            bypass[i] = dis_q || os_act || (os_com && !k_in[i]);
            k_bad[i]  = k_in[i] && !pcie_phy_pkg::is_legal_k(sym_in[i]);

            if (is_com) begin
                os_act = 1'b0;
                os_com = 1'b1;
                os_cnt = 4'd1;
            end else if (os_com) begin
                os_com = 1'b0;
                if (!k_in[i]) begin
                    os_act = 1'b1;
                    os_cnt = 4'd2;
                end
            end else if (os_act) begin
                if (is_pkt || os_cnt == OS_LAST)
                    os_act = 1'b0;
                else
                    os_cnt = os_cnt + 4'd1;
            end
        end
    end

    scramble_byte #(.SEED(LFSR_SEED)) u_byte_1 (
        .sym      (sym_in[0]),
        .k        (k_in[0]),
        .bypass   (bypass[0]),
        .lfsr_in  (lfsr_q),
        .sym_scr  (sym_scr[0]),
        .lfsr_out (lfsr_1)
    );

    scramble_byte #(.SEED(LFSR_SEED)) u_byte_2 (
        .sym      (sym_in[1]),
        .k        (k_in[1]),
        .bypass   (bypass[1]),
        .lfsr_in  (lfsr_1),
        .sym_scr  (sym_scr[1]),
        .lfsr_out (lfsr_2)
    );

    scramble_byte #(.SEED(LFSR_SEED)) u_byte_3 (
        .sym      (sym_in[2]),
        .k        (k_in[2]),
        .bypass   (bypass[2]),
        .lfsr_in  (lfsr_2),
        .sym_scr  (sym_scr[2]),
        .lfsr_out (lfsr_3)
    );

    scramble_byte #(.SEED(LFSR_SEED)) u_byte_4 (
        .sym      (sym_in[3]),
        .k        (k_in[3]),
        .bypass   (bypass[3]),
        .lfsr_in  (lfsr_3),
        .sym_scr  (sym_scr[3]),
        .lfsr_out (lfsr_4)
    );

    // scramble_disable is registered so a whole input cycle sees one value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q      <= LFSR_SEED;
            os_active_q <= 1'b0;
            com_seen_q  <= 1'b0;
            os_cnt_q    <= 4'd0;
            dis_q       <= 1'b0;
            sym_out_1   <= 8'h00;
            sym_out_2   <= 8'h00;
            sym_out_3   <= 8'h00;
            sym_out_4   <= 8'h00;
            k_out       <= 4'h0;
            invalid_k   <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_4;
            os_active_q <= os_act;
            com_seen_q  <= os_com;
            os_cnt_q    <= os_cnt;
            dis_q       <= scramble_disable;
            sym_out_1   <= sym_scr[0];
            sym_out_2   <= sym_scr[1];
            sym_out_3   <= sym_scr[2];
            sym_out_4   <= sym_scr[3];
            k_out       <= k_in;
            invalid_k   <= |k_bad;
        end
    end

endmodule
